dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter AW, default 12: dmem word-address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter MAX_BURST, default 4: max consecutive grants to one requester while the other is waiting; legal range 1..15.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req0, req1  in  1 each  access request; requester 0 = processor, requester 1 = loader/debug port.
REQ-007 we0, we1  in  1 each  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0, addr1  in  AW each  word address.
REQ-009 wdata0, wdata1  in  DW each  write data.
REQ-010 gnt0, gnt1  out  1 each  combinational grant; access performed this cycle.
REQ-011 rvalid0, rvalid1  out  1 each  registered; read data valid for that requester.
REQ-012 rdata0, rdata1  out  DW each  read data.
REQ-013 address_dmem  out  AW  to dmem address.
REQ-014 data  out  DW  to dmem write data.
REQ-015 wren  out  1  to dmem write enable.
REQ-016 q_dmem  in  DW  from dmem; valid one cycle after the read address is presented.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-018 gnt0 = gnt1 = 0 SHALL hold in any cycle where reset is high or neither req is high.
REQ-019 If exactly one reqN is high (reset low), that requester SHALL be granted the same cycle.
REQ-020 State: last (1 bit, last granted requester), burst_cnt (4 bits, consecutive grants to last).
REQ-021 Both requesting, previous cycle granted last, burst_cnt < MAX_BURST: grant last.
REQ-022 Both requesting, burst_cnt == MAX_BURST or previous cycle had no grant: grant ~last.
REQ-023 On a grant to the same requester as in the previous cycle: burst_cnt increments, saturating at MAX_BURST.
REQ-024 On a grant to a different requester, or the first grant after an idle cycle: burst_cnt = 1, last = granted requester.
REQ-025 Cycle with no grant: burst_cnt = 0; last unchanged.
REQ-026 A lone requester SHALL never be throttled by burst_cnt; it is granted every cycle it requests.
REQ-027 With a grant: address_dmem = addrN and data = wdataN of the granted N; wren = weN.
REQ-028 Without a grant: address_dmem = 0, data = 0, wren = 0.
REQ-029 Granted read (weN = 0): rvalidN SHALL be high exactly the next cycle, with rdataN = q_dmem that cycle; the other requester's rvalid stays 0.
REQ-030 Granted write: no rvalid pulse.
REQ-031 rdataN SHALL be 0 whenever rvalidN = 0.
REQ-032 Back-to-back reads SHALL be supported: a read granted in cycle t+1 yields rvalid in t+2 regardless of owner; the rvalid owner is tracked by a registered tag, not by the current grant.
REQ-033 Ungranted requesters SHALL hold req, we, addr and wdata stable until granted; the arbiter does not latch them.

Reset
REQ-034 While reset is high at a rising edge, the next state SHALL be: last = 1, burst_cnt = 0, rvalid0 = rvalid1 = 0, read tag cleared.
REQ-035 During reset: gnt0/gnt1 = 0, wren = 0, address_dmem = 0, data = 0.
REQ-036 A read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-037 First contention after reset SHALL go to requester 0.

Verification
REQ-038 After reset, req0 = 1, we0 = 1, addr0 = 0x010, wdata0 = 0xDEADBEEF -> gnt0 = 1 the same cycle; wren = 1, address_dmem = 0x010, data = 0xDEADBEEF; no rvalid.
REQ-039 req1 read of 0x010 after the write -> gnt1 = 1; next cycle rvalid1 = 1, rdata1 = 0xDEADBEEF; rvalid0 = 0.
REQ-040 Both requesting continuously from reset, MAX_BURST = 4 -> grant pattern 0,0,0,0,1,1,1,1,0,... with never more than 4 in a row.
REQ-041 req0 alone for 10 cycles -> gnt0 = 1 on all 10 cycles.
REQ-042 Alternating reads from req0 (addr 0x001) and req1 (addr 0x002) in consecutive cycles -> each rvalid pulse routed to the correct requester with the matching q_dmem.
REQ-043 Read granted, reset asserted the next cycle -> rvalid0 = rvalid1 = 0, all dmem outputs 0; first contention after reset is granted to requester 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory arbiter: a processor port and a loader/debug port share one
// synchronous dmem, with burst-limited fairness and a tagged one-cycle read return path.
module dmem_port_arbiter #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] address_dmem,
  output logic [DW-1:0] data,
  output logic          wren,
  input  logic [DW-1:0] q_dmem
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  logic       r_last;
  logic [3:0] r_cnt;
  logic       r_rvalid;
  logic       r_rtag;

  logic       w_any;
  logic       w_keep;
  logic       w_sel;
  logic       w_we;

  // r_cnt == 0 doubles as "no grant last cycle", which hands contention to the other side.
  always_comb begin
    w_any  = !reset && (req0 || req1);
    w_keep = (r_cnt != '0) && (r_cnt < LP_MAX);
    if (req0 && req1) w_sel = w_keep ? r_last : ~r_last;
    else              w_sel = req1;
    w_we   = w_sel ? we1 : we0;
  end

  always_comb begin
    gnt0         = w_any & ~w_sel;
    gnt1         = w_any &  w_sel;
    wren         = w_any & w_we;
    address_dmem = '0;
    data         = '0;
    if (w_any) begin
      address_dmem = w_sel ? addr1  : addr0;
      data         = w_sel ? wdata1 : wdata0;
    end
  end

  // Reset also masks a return already in flight from the cycle before it asserted.
  always_comb begin
    rvalid0 = r_rvalid & ~r_rtag & ~reset;
    rvalid1 = r_rvalid &  r_rtag & ~reset;
    rdata0  = rvalid0 ? q_dmem : '0;
    rdata1  = rvalid1 ? q_dmem : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rtag   <= 1'b0;
    end else begin
      r_rvalid <= w_any & ~w_we;
      r_rtag   <= w_sel;
      if (!w_any) begin
        r_cnt <= '0;
      end else if ((r_cnt != '0) && (w_sel == r_last)) begin
        if (r_cnt != LP_MAX) r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt  <= 4'd1;
        r_last <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, burst and lone-requester sequences,
// then constrained-random traffic against a history-based reference model.
module tb_dmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, wren;
  logic [DW-1:0] rdata0, rdata1, data, q_dmem;
  logic [AW-1:0] address_dmem;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  // Synchronous dmem: registered read, one-cycle latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: grant history and expected memory contents.
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  bit            m_last = 1'b1;
  int            m_run  = 0;
  bit            m_prev = 1'b0;
  bit            m_pv0 = 1'b0, m_pv1 = 1'b0;
  logic [DW-1:0] m_pd = '0;

  logic a_g0, a_g1, a_v0, a_v1;
  logic [DW-1:0] a_q0, a_q1;

  // Inputs are already driven (posedge+1); check mid-cycle, advance model, move to next posedge+1.
  task automatic cycle();
    bit any, sel, e_wren, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    #3;
    any = !reset && (req0 || req1);
    if (req0 && req1) sel = (m_prev && m_run < MB) ? m_last : !m_last;
    else              sel = req1;
    e_addr = any ? (sel ? addr1 : addr0) : '0;
    e_data = any ? (sel ? wdata1 : wdata0) : '0;
    e_wren = any && (sel ? we1 : we0);
    e_rv0  = !reset && m_pv0;
    e_rv1  = !reset && m_pv1;
    a_g0 = gnt0; a_g1 = gnt1; a_v0 = rvalid0; a_v1 = rvalid1; a_q0 = rdata0; a_q1 = rdata1;
    chk("gnt0", gnt0, any && !sel);
    chk("gnt1", gnt1, any && sel);
    chk("wren", wren, e_wren);
    chk("address_dmem", address_dmem, e_addr);
    chk("data", data, e_data);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata0", rdata0, e_rv0 ? m_pd : '0);
    chk("rdata1", rdata1, e_rv1 ? m_pd : '0);
    if (reset) begin
      m_last = 1'b1; m_run = 0; m_prev = 1'b0; m_pv0 = 1'b0; m_pv1 = 1'b0;
    end else if (any) begin
      if (m_prev && sel == m_last) m_run++;
      else begin m_run = 1; m_last = sel; end
      m_prev = 1'b1;
      m_pv0  = !sel && !e_wren;
      m_pv1  =  sel && !e_wren;
      m_pd   = exp_mem[e_addr];
      if (e_wren) exp_mem[e_addr] = e_data;
    end else begin
      m_run = 0; m_prev = 1'b0; m_pv0 = 1'b0; m_pv1 = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit rst;
    bit r0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit r1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit g0; bit g1; bit v0; bit v1; logic [DW-1:0] q0; logic [DW-1:0] q1;
  } vec_t;

  vec_t tbl [16];

  task automatic drive(input bit rst, input bit r0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit r1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    int pat [12];
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    //            rst r0 w0 a0      d0            r1 w1 a1      d1            g0 g1 v0 v1 q0            q1
    tbl[0]  = '{1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    tbl[1]  = '{1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    tbl[2]  = '{0, 1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    tbl[3]  = '{0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h010, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0};
    tbl[4]  = '{0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 32'h0,        32'hDEADBEEF};
    tbl[5]  = '{0, 0, 0, 12'h000, 32'h0,        1, 1, 12'h002, 32'h22222222, 0, 1, 0, 0, 32'h0,        32'h0};
    tbl[6]  = '{0, 1, 1, 12'h001, 32'h11111111, 0, 0, 12'h000, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    tbl[7]  = '{0, 1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    tbl[8]  = '{0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h002, 32'h0,        0, 1, 1, 0, 32'h11111111, 32'h0};
    tbl[9]  = '{0, 1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,        1, 0, 0, 1, 32'h0,        32'h22222222};
    tbl[10] = '{0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h002, 32'h0,        0, 1, 1, 0, 32'h11111111, 32'h0};
    tbl[11] = '{0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 32'h0,        32'h22222222};
    tbl[12] = '{0, 1, 0, 12'h001, 32'h0,        0, 0, 12'h000, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    tbl[13] = '{1, 1, 0, 12'h001, 32'h0,        1, 0, 12'h002, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    tbl[14] = '{0, 1, 0, 12'h001, 32'h0,        1, 0, 12'h002, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    tbl[15] = '{0, 1, 0, 12'h001, 32'h0,        1, 0, 12'h002, 32'h0,        1, 0, 1, 0, 32'h11111111, 32'h0};

    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      cycle();
      chk($sformatf("tbl%0d_gnt0", i), a_g0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), a_g1, tbl[i].g1);
      chk($sformatf("tbl%0d_rvalid0", i), a_v0, tbl[i].v0);
      chk($sformatf("tbl%0d_rvalid1", i), a_v1, tbl[i].v1);
      chk($sformatf("tbl%0d_rdata0", i), a_q0, tbl[i].q0);
      chk($sformatf("tbl%0d_rdata1", i), a_q1, tbl[i].q1);
    end

    // Continuous contention from reset: bursts of MAX_BURST, starting with requester 0.
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    cycle();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1, 12'h020, 32'hA0A0_0000 + i, 1, 1, 12'h021, 32'hB0B0_0000 + i);
      cycle();
      chk($sformatf("burst%0d_gnt1", i), a_g1, pat[i]);
      chk($sformatf("burst%0d_gnt0", i), a_g0, !pat[i]);
    end

    // Lone requester is never throttled.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 12'h030, 32'hC0C0_0000 + i, 0, 0, '0, '0);
      cycle();
      chk($sformatf("lone%0d_gnt0", i), a_g0, 1'b1);
    end

    // Random traffic; a waiting requester holds its request until granted.
    for (int i = 0; i < 400; i++) begin
      bool_hold0: begin
        if (!(req0 && !a_g0)) begin
          req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom_range(0, 1));
          addr0 = AW'($urandom_range(0, 15)); wdata0 = $urandom;
        end
      end
      if (!(req1 && !a_g1)) begin
        req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15)); wdata1 = $urandom;
      end
      reset = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
